reg_write_bank: RTL and testbench

//  Write side of the PE register file: holds the 32 x 32-bit architectural registers and drives them flattened

---
 rtl/rf_pkg.sv | 14 +
 rtl/wb_fifo.sv | 69 ++++++
 rtl/reg_write_bank.sv | 81 ++++++++
 tb/tb_reg_write_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizes and the writeback request payload for the PE register file.
package rf_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned RIDX_W     = $clog2(NREGS);
    localparam int unsigned FIFO_DEPTH = 2;

    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage : rf_pkg

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; count is kept apart from the wrapping pointers.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_req_t          wdata_i,
    input  logic             pop_i,
    output wb_req_t          rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop_i) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared on reset so buffered entries are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule : wb_fifo

// File: rtl/reg_write_bank.sv
// Write side of the PE register file: buffers writebacks and commits one per idle-read cycle.
module reg_write_bank
    import rf_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = rf_pkg::FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [RIDX_W-1:0]       wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    read_busy,
    output logic [NREGS*XLEN-1:0]   regs_flat,
    output logic                    wb_complete,
    output logic [CNT_W-1:0]        wb_pending
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            complete_q;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    wb_req_t         push_req;
    wb_req_t         head_req;

    // Ready depends only on occupancy so a full FIFO always stalls at least one cycle.
    assign wb_ready = !rst && !fifo_full;
    assign push     = wb_valid && wb_ready;
    assign pop      = !fifo_empty && !read_busy;

    assign push_req.rd   = wb_rd;
    assign push_req.data = wb_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (wb_pending)
    );

    // Commit the FIFO head into the register array; x0 is hardwired to zero.
    always_comb begin
        regs_d = regs_q;
        if (pop && (head_req.rd != '0)) begin
            regs_d[head_req.rd] = head_req.data;
        end
    end

    // Register array and commit-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            complete_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            complete_q <= pop;
        end
    end

    assign wb_complete = complete_q;

    // Flatten for the read mux: register k lands at [k*XLEN +: XLEN].
    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_flat[k*XLEN +: XLEN] = regs_q[k];
    end

endmodule : reg_write_bank

// File: tb/tb_reg_write_bank.sv
// Self-checking bench for reg_write_bank against a queue-based register file model.
module tb_reg_write_bank;
    import rf_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [RIDX_W-1:0]     wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  read_busy;
    logic [NREGS*XLEN-1:0] regs_flat;
    logic                  wb_complete;
    logic [1:0]            wb_pending;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned pulses     = 0;

    // model state
    logic [XLEN-1:0] m_regs [NREGS];
    wb_req_t         m_q [$];
    logic            m_complete;

    reg_write_bank dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .read_busy   (read_busy),
        .regs_flat   (regs_flat),
        .wb_complete (wb_complete),
        .wb_pending  (wb_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NREGS*XLEN-1:0] obs,
                       input logic [NREGS*XLEN-1:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREGS*XLEN-1:0] model_flat();
        logic [NREGS*XLEN-1:0] f;
        for (int k = 0; k < NREGS; k++) f[k*XLEN +: XLEN] = m_regs[k];
        return f;
    endfunction

    function automatic logic [XLEN-1:0] dut_reg(input int k);
        return regs_flat[k*XLEN +: XLEN];
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, check all outputs.
    task automatic step(input logic v, input logic [RIDX_W-1:0] rd, input logic [XLEN-1:0] d,
                        input logic busy, input logic r);
        logic    acc;
        logic    pop_m;
        wb_req_t e;
        rst       = r;
        wb_valid  = v;
        wb_rd     = v ? rd : 'x;
        wb_data   = v ? d  : 'x;
        read_busy = busy;
        #1;
        chk("ready", {1023'b0, wb_ready}, {1023'b0, (!r && m_q.size() < FIFO_DEPTH)});
        if (r) begin
            m_q.delete();
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
            m_complete = 1'b0;
        end else begin
            acc   = v && (m_q.size() < FIFO_DEPTH);
            pop_m = (m_q.size() > 0) && !busy;
            if (pop_m) begin
                e = m_q.pop_front();
                if (e.rd != 0) m_regs[e.rd] = e.data;
            end
            if (acc) m_q.push_back('{rd: rd, data: d});
            m_complete = pop_m;
        end
        @(posedge clk);
        #1;
        chk("regs_flat", regs_flat, model_flat());
        chk("pending", {1022'b0, wb_pending}, {1022'b0, 2'(m_q.size())});
        chk("complete", {1023'b0, wb_complete}, {1023'b0, m_complete});
        if (wb_complete === 1'b1) pulses++;
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) m_regs[k] = 'x;
        m_complete = 1'bx;

        // 1: reset, then idle
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("rst_regs_zero", regs_flat, '0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("ready_after_rst", {1023'b0, wb_ready}, 1024'd1);

        // 2: single write to r5, committed one edge after acceptance
        pulses = 0;
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("r5_not_yet", {992'b0, dut_reg(5)}, 1024'd0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("r5_written", {992'b0, dut_reg(5)}, {992'b0, 32'hDEADBEEF});
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("t2_pulses", 1024'(pulses), 1024'd1);

        // 3: read_busy holds commits; FIFO fills and stalls the third write
        pulses = 0;
        step(1'b1, 5'd1, 32'hA1, 1'b1, 1'b0);
        step(1'b1, 5'd2, 32'hA2, 1'b1, 1'b0);
        step(1'b1, 5'd3, 32'hA3, 1'b1, 1'b0);
        chk("t3_full_ready", {1023'b0, wb_ready}, 1024'd0);
        chk("t3_pending2", {1022'b0, wb_pending}, 1024'd2);
        step(1'b1, 5'd3, 32'hA3, 1'b0, 1'b0);
        step(1'b1, 5'd3, 32'hA3, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("t3_r3", {992'b0, dut_reg(3)}, {992'b0, 32'hA3});
        chk("t3_pulses", 1024'(pulses), 1024'd3);

        // 4: x0 write pulses complete but r0 stays zero
        pulses = 0;
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("t4_r0", {992'b0, dut_reg(0)}, 1024'd0);
        chk("t4_pulses", 1024'(pulses), 1024'd1);

        // 5: back-to-back writes to r7, last one wins
        step(1'b1, 5'd7, 32'h11, 1'b0, 1'b0);
        step(1'b1, 5'd7, 32'h22, 1'b0, 1'b0);
        chk("t5_r7_mid", {992'b0, dut_reg(7)}, {992'b0, 32'h11});
        step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("t5_r7_final", {992'b0, dut_reg(7)}, {992'b0, 32'h22});

        // 6: reset while FIFO is full discards pending writes
        step(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        step(1'b1, 5'd10, 32'hAA, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        chk("t6_regs_zero", regs_flat, '0);
        pulses = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("t6_no_pulses", 1024'(pulses), 1024'd0);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_reg_write_bank
